// File: rtl/rotl_seq.sv
// Iterative left rotator: one log-shifter stage per clock, valid/ready in and out.
// Optional ROTL_EARLY_EXIT_EN finishes as soon as no higher amount bits remain.
module rotl_seq #(
  parameter int AMT_W = 5,
  localparam int WIDTH = 2 ** AMT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [AMT_W-1:0] K_LAST = AMT_W'(AMT_W - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] stage_out;
  logic [AMT_W-1:0] amt_r;
  logic [AMT_W-1:0] k;
  logic [AMT_W-1:0] rot_dist;
  logic             last_stage;

  // Stage k rotates by 2^k; rot_dist is never zero so the right shift stays below WIDTH.
  always_comb begin
    rot_dist  = AMT_W'(1) << k;
    stage_out = data_r;
    if (amt_r[k]) begin
      stage_out = (data_r << rot_dist) | (data_r >> (WIDTH - int'(rot_dist)));
    end
`ifdef ROTL_EARLY_EXIT_EN
    last_stage = ((amt_r >> k) >> 1) == '0;
`else
    last_stage = (k == K_LAST);
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_stage) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // dout_r is loaded only on the edge that enters DONE, so it holds through backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_r <= '0;
      amt_r  <= '0;
      k      <= '0;
      dout_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_r <= din;
            amt_r  <= amount;
            k      <= '0;
          end
        end
        BUSY: begin
          data_r <= stage_out;
          k      <= k + AMT_W'(1);
          if (last_stage) begin
            dout_r <= stage_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == BUSY);
  assign out_valid = (state == DONE);
  assign dout      = dout_r;

endmodule

// File: tb/tb_rotl_seq.sv
// Self-checking bench for rotl_seq: directed cases, backpressure, mid-BUSY reset, random words.
// Expected latency follows ROTL_EARLY_EXIT_EN when that macro is defined.
module tb_rotl_seq;

  localparam int AMT_W = 5;
  localparam int WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic             busy;

  int tests = 0;
  int fails = 0;

  rotl_seq #(.AMT_W(AMT_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .amount    (amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  // Reference rotate: move the top bit to the bottom, one position at a time.
  function automatic logic [31:0] refRotl(input logic [31:0] x, input int a);
    logic [31:0] y;
    y = x;
    for (int i = 0; i < a; i++) y = {y[30:0], y[31]};
    return y;
  endfunction

  function automatic int refLatency(input int a);
`ifdef ROTL_EARLY_EXIT_EN
    int m;
    m = 0;
    for (int i = 0; i < AMT_W; i++) if (((a >> i) & 1) == 1) m = i + 1;
    return (m == 0) ? 1 : m;
`else
    return AMT_W;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] d, input int a, output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    din      = d;
    amount   = a[AMT_W-1:0];
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    waitDone(lat);
  endtask

  task automatic runTransaction(input string tag, input logic [31:0] d, input int a,
                                input logic [31:0] expected, input int stall);
    int lat;
    applyStimulus(d, a, lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(refLatency(a)));
    checkOutput({tag, "_dout"}, dout, expected);
    repeat (stall) begin
      @(posedge clock); #1;
      checkOutput({tag, "_stall_dout"}, dout, expected);
    end
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] r_din;
    int r_amt;

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
    amount    = '0;
    #12;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_dout", dout, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    runTransaction("basic", 32'h8000_0001, 1, 32'h0000_0003, 0);
    runTransaction("nibble", 32'h1234_5678, 4, 32'h2345_6781, 0);
    runTransaction("amt0", 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1);
    runTransaction("amt31", 32'h0000_0001, 31, 32'h8000_0000, 0);
    runTransaction("inverse", 32'hAAAA_AAAA, 1, 32'h5555_5555, 2);

    // Backpressure with in_valid pulsing while the result is stalled in DONE.
    applyStimulus(32'h0F0F_0000, 8, lat);
    checkOutput("bp_latency", 32'(lat), 32'(refLatency(8)));
    checkOutput("bp_dout", dout, 32'h0F00_000F);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      din      = $urandom;
      amount   = 5'd3;
      @(posedge clock); #1;
      checkOutput("bp_hold_dout", dout, 32'h0F00_000F);
      checkOutput("bp_hold_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b1;
    din       = 32'h0000_0010;
    amount    = 5'd2;
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_no_bypass", 32'(busy), 32'd0);
    checkOutput("bp_release_dout", dout, 32'h0F00_000F);
    @(posedge clock); #1;
    in_valid = 1'b0;
    checkOutput("bp_next_busy", 32'(busy), 32'd1);
    checkOutput("bp_next_in_ready", 32'(in_ready), 32'd0);
    waitDone(lat);
    checkOutput("bp_next_latency", 32'(lat), 32'(refLatency(2)));
    checkOutput("bp_next_dout", dout, refRotl(32'h0000_0010, 2));
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;

    // Reset two cycles into a long rotate; dout still holds the previous nonzero result.
    din      = 32'h0000_0001;
    amount   = 5'd31;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    checkOutput("midbusy_busy_before_reset", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midbusy_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midbusy_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midbusy_dout", dout, 32'd0);
    checkOutput("midbusy_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    runTransaction("after_reset", 32'hC000_0003, 3, 32'h0000_001E, 0);

    for (int n = 0; n < 24; n++) begin
      r_din = $urandom;
      r_amt = int'($urandom_range(0, WIDTH - 1));
      runTransaction("random", r_din, r_amt, refRotl(r_din, r_amt), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
